// File: rtl/pic16_tmr0_pkg.sv
// pic16_tmr0_pkg: register addresses, OPTION field indices and prescaler helpers for Timer0
package pic16_tmr0_pkg;
  localparam logic [8:0] A_MASK   = 9'h0FF;
  localparam logic [8:0] A_TMR0   = 9'h001;
  localparam logic [8:0] A_OPTION = 9'h081;
  localparam int T0CS = 5;
  localparam int T0SE = 4;
  localparam int PSA  = 3;
  localparam int PS   = 0;
  localparam logic [7:0] OPTION_RST = 8'hFF;
  function automatic logic [7:0] ps_mask(input logic [2:0] ps);
    return 8'((9'd2 << ps) - 9'd1);
  endfunction
endpackage

// File: rtl/pic16_tmr0_t0cki_sync.sv
// t0cki_sync: synchronizes T0CKI and emits a one-cycle EDGE on the edge chosen by T0SE
module t0cki_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic T0CKI,
  input  logic T0SE,
  output logic EDGE
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], T0CKI};
      prev <= sync[SYNC_STAGES-1];
    end
  end
  // a change whose new level differs from T0SE is the selected edge (rise for 0, fall for 1)
  assign EDGE = (sync[SYNC_STAGES-1] ^ prev) & (sync[SYNC_STAGES-1] ^ T0SE);
endmodule

// File: rtl/pic16_tmr0.sv
// pic16_tmr0: TMR0 counter, OPTION register and shared prescaler on the core special-register path
module pic16_tmr0
  import pic16_tmr0_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WE,
  input  logic [8:0] EA,
  input  logic [7:0] WDATA,
  output logic       SEL,
  output logic [7:0] RDATA,
  input  logic       T0CKI,
  input  logic       T0IF_CLR,
  output logic       T0IF,
  output logic [7:0] OPTION
);
  logic [7:0] tmr0, psc, mask;
  logic [1:0] inh;
  logic hit_tmr, hit_opt, wr_tmr, wr_opt, ext_edge, ev, tick;
  t0cki_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK(CLK),
    .RST(RST),
    .T0CKI(T0CKI),
    .T0SE(OPTION[T0SE]),
    .EDGE(ext_edge)
  );
  assign hit_tmr = (EA & A_MASK) == A_TMR0;
  assign hit_opt = (EA & A_MASK) == A_OPTION;
  assign wr_tmr  = WE & hit_tmr;
  assign wr_opt  = WE & hit_opt;
  assign SEL     = hit_tmr | hit_opt;
  assign RDATA   = hit_tmr ? tmr0 : hit_opt ? OPTION : 8'h00;
  assign mask    = ps_mask(OPTION[PS +: 3]);
  // events are dropped entirely while the post-write inhibit is running
  assign ev      = (OPTION[T0CS] ? ext_edge : 1'b1) & (inh == 2'd0);
  assign tick    = ev & (OPTION[PSA] | ((psc & mask) == mask));
  always_ff @(posedge CLK) begin
    if (RST) begin
      tmr0   <= 8'h00;
      OPTION <= OPTION_RST;
      psc    <= 8'h00;
      inh    <= 2'd0;
      T0IF   <= 1'b0;
    end else begin
      tmr0   <= wr_tmr ? WDATA : tmr0 + 8'(tick);
      OPTION <= wr_opt ? WDATA : OPTION;
      psc    <= (wr_tmr | wr_opt | OPTION[PSA]) ? 8'h00 : psc + 8'(ev);
      inh    <= wr_tmr ? 2'd2 : inh - 2'(inh != 2'd0);
      T0IF   <= (tick & (tmr0 == 8'hFF) & ~wr_tmr) | (T0IF & ~T0IF_CLR);
    end
  end
endmodule

// File: tb/tb_pic16_tmr0.sv
// tb_pic16_tmr0: vector table, corner sequences and random traffic against a behavioural Timer0 model
module tb_pic16_tmr0;
  localparam int S = 2;
  logic CLK = 1'b0;
  logic RST, WE, T0CKI, T0IF_CLR, SEL, T0IF;
  logic [8:0] EA;
  logic [7:0] WDATA, RDATA, OPTION;
  int checks = 0, errors = 0;
  pic16_tmr0 #(.SYNC_STAGES(S)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .EA(EA), .WDATA(WDATA), .SEL(SEL), .RDATA(RDATA),
    .T0CKI(T0CKI), .T0IF_CLR(T0IF_CLR), .T0IF(T0IF), .OPTION(OPTION)
  );
  always #5 CLK = ~CLK;
  int m_tmr, m_opt, m_psc, m_if, cyc, last_wr;
  bit hist[$];
  typedef struct {
    bit r; bit w; logic [8:0] a; logic [7:0] d; bit c;
    logic [7:0] rd; bit f; logic [7:0] opt; bit sel;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // model: timer value, prescale count, and the cycle number of the last TMR0 write
  task automatic model(input bit r, input bit w, input logic [8:0] a, input logic [7:0] d, input bit c, input bit t);
    bit wt, wo, ev, tick, e_new, e_old;
    int ratio;
    cyc++;
    if (r) begin
      m_tmr = 0; m_opt = 255; m_psc = 0; m_if = 0; last_wr = -100;
      hist = {};
      repeat (S + 1) hist.push_back(1'b0);
      return;
    end
    hist.push_back(t);
    e_new = hist[hist.size() - 1 - S];
    e_old = hist[hist.size() - 2 - S];
    void'(hist.pop_front());
    wt = w && a[7:0] == 8'h01;
    wo = w && a[7:0] == 8'h81;
    ev = (m_opt[5] ? (e_new != e_old && e_new != m_opt[4]) : 1'b1) && (cyc - last_wr > 2);
    ratio = 2 << m_opt[2:0];
    tick = ev && (m_opt[3] || (m_psc % ratio) == ratio - 1);
    if (tick && m_tmr == 255 && !wt) m_if = 1;
    else if (c) m_if = 0;
    m_tmr = wt ? int'(d) : (m_tmr + int'(tick)) % 256;
    m_psc = (wt || wo || m_opt[3]) ? 0 : (m_psc + int'(ev)) % 256;
    if (wt) last_wr = cyc;
    if (wo) m_opt = int'(d);
  endtask
  task automatic step(input bit r, input bit w, input logic [8:0] a, input logic [7:0] d, input bit c, input bit t);
    RST = r; WE = w; EA = a; WDATA = d; T0IF_CLR = c; T0CKI = t;
    model(r, w, a, d, c, t);
    @(posedge CLK);
    #1;
    chk("model_rdata", RDATA, a[7:0] == 8'h01 ? m_tmr : a[7:0] == 8'h81 ? m_opt : 0);
    chk("model_t0if", T0IF, m_if);
    chk("model_option", OPTION, m_opt);
    chk("model_sel", SEL, a[6:0] == 7'h01);
  endtask
  task automatic wait_change(input logic [7:0] base, output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      step(0, 0, 9'h001, 8'h00, 0, 0);
      if (RDATA !== base) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic v(input bit r, input bit w, input logic [8:0] a, input logic [7:0] d, input bit c,
                   input logic [7:0] rd, input bit f, input logic [7:0] opt, input bit sel);
    tv.push_back('{r, w, a, d, c, rd, f, opt, sel});
  endtask
  initial begin
    int n, hold;
    bit pin;
    logic [8:0] eas[6] = '{9'h001, 9'h081, 9'h101, 9'h181, 9'h005, 9'h0C1};
    logic [8:0] a;
    cyc = 0;
    v(1, 0, 9'h001, 8'h00, 0, 8'h00, 0, 8'hFF, 1);
    v(1, 0, 9'h081, 8'h00, 0, 8'hFF, 0, 8'hFF, 1);
    v(0, 1, 9'h081, 8'h08, 0, 8'h08, 0, 8'h08, 1);
    v(0, 0, 9'h001, 8'h00, 0, 8'h01, 0, 8'h08, 1);
    v(0, 0, 9'h001, 8'h00, 0, 8'h02, 0, 8'h08, 1);
    v(0, 0, 9'h001, 8'h00, 0, 8'h03, 0, 8'h08, 1);
    v(0, 1, 9'h001, 8'hFD, 0, 8'hFD, 0, 8'h08, 1);
    v(0, 0, 9'h001, 8'h00, 0, 8'hFD, 0, 8'h08, 1);
    v(0, 0, 9'h001, 8'h00, 0, 8'hFD, 0, 8'h08, 1);
    v(0, 0, 9'h001, 8'h00, 0, 8'hFE, 0, 8'h08, 1);
    v(0, 0, 9'h001, 8'h00, 0, 8'hFF, 0, 8'h08, 1);
    v(0, 0, 9'h001, 8'h00, 0, 8'h00, 1, 8'h08, 1);
    v(0, 0, 9'h001, 8'h00, 0, 8'h01, 1, 8'h08, 1);
    v(0, 0, 9'h001, 8'h00, 1, 8'h02, 0, 8'h08, 1);
    v(0, 1, 9'h005, 8'h55, 0, 8'h00, 0, 8'h08, 0);
    v(0, 1, 9'h0C1, 8'h55, 0, 8'h00, 0, 8'h08, 0);
    v(0, 0, 9'h101, 8'h00, 0, 8'h05, 0, 8'h08, 1);
    v(0, 0, 9'h181, 8'h00, 0, 8'h08, 0, 8'h08, 1);
    v(0, 1, 9'h101, 8'h40, 0, 8'h40, 0, 8'h08, 1);
    v(0, 1, 9'h181, 8'h09, 0, 8'h09, 0, 8'h09, 1);
    v(0, 0, 9'h001, 8'h00, 0, 8'h40, 0, 8'h09, 1);
    v(0, 0, 9'h001, 8'h00, 0, 8'h41, 0, 8'h09, 1);
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].c, 0);
      chk($sformatf("vec%0d_rdata", i), RDATA, tv[i].rd);
      chk($sformatf("vec%0d_t0if", i), T0IF, tv[i].f);
      chk($sformatf("vec%0d_option", i), OPTION, tv[i].opt);
      chk($sformatf("vec%0d_sel", i), SEL, tv[i].sel);
    end
    // 1:16 prescale; the tick coinciding with the OPTION write still lands
    step(0, 1, 9'h081, 8'h03, 0, 0);
    wait_change(8'h42, n);
    chk("psc16_first", n, 16);
    chk("psc16_first_val", RDATA, 8'h43);
    wait_change(8'h43, n);
    chk("psc16_second", n, 16);
    step(0, 1, 9'h081, 8'h00, 0, 0);
    wait_change(8'h44, n);
    chk("psc2_after_rewrite", n, 2);
    chk("psc2_val", RDATA, 8'h45);
    // external rising edges, then falling edges
    step(0, 1, 9'h081, 8'h28, 0, 0);
    step(0, 1, 9'h001, 8'h00, 0, 0);
    repeat (3) step(0, 0, 9'h001, 8'h00, 0, 0);
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 8; i++) begin
        step(0, 0, 9'h001, 8'h00, 0, i < 4);
        chk($sformatf("ext_rise%0d_%0d", p, i), RDATA, i < 2 ? p : p + 1);
      end
    step(0, 1, 9'h081, 8'h38, 0, 0);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 8; i++) begin
        step(0, 0, 9'h001, 8'h00, 0, i < 4);
        chk($sformatf("ext_fall%0d_%0d", p, i), RDATA, i < 6 ? 5 + p : 6 + p);
      end
    // collisions and mid-count reset
    step(0, 1, 9'h081, 8'h08, 0, 0);
    step(0, 1, 9'h001, 8'hFF, 0, 0);
    repeat (2) step(0, 0, 9'h001, 8'h00, 0, 0);
    step(0, 0, 9'h001, 8'h00, 1, 0);
    chk("set_beats_clr_tmr", RDATA, 8'h00);
    chk("set_beats_clr_if", T0IF, 1'b1);
    step(0, 0, 9'h001, 8'h00, 1, 0);
    chk("clr_if", T0IF, 1'b0);
    step(0, 1, 9'h001, 8'hFE, 0, 0);
    repeat (3) step(0, 0, 9'h001, 8'h00, 0, 0);
    chk("pre_collide", RDATA, 8'hFF);
    step(0, 1, 9'h001, 8'h10, 0, 0);
    chk("write_wins_tmr", RDATA, 8'h10);
    chk("write_wins_if", T0IF, 1'b0);
    step(0, 1, 9'h001, 8'hFF, 0, 0);
    repeat (3) step(0, 0, 9'h001, 8'h00, 0, 0);
    chk("ovf_before_rst", T0IF, 1'b1);
    step(0, 0, 9'h001, 8'h00, 0, 0);
    step(1, 0, 9'h001, 8'h00, 0, 0);
    chk("rst_tmr", RDATA, 8'h00);
    chk("rst_if", T0IF, 1'b0);
    chk("rst_option", OPTION, 8'hFF);
    // random traffic against the model
    pin = 0;
    hold = 4;
    for (int k = 0; k < 4000; k++) begin
      if (hold == 0) begin
        pin = ~pin;
        hold = $urandom_range(3, 8);
      end
      hold--;
      a = ($urandom_range(0, 9) == 0) ? 9'($urandom) : eas[$urandom_range(0, 5)];
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, a, 8'($urandom),
           $urandom_range(0, 19) == 0, pin);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
